// File: rtl/pwm_gen_core_if.sv
// pwm_gen_core_if
// Bundles the configuration inputs and status/PWM outputs of pwm_gen_core.
//   master : register-file side, drives cfg_* and observes the outputs
//   slave  : timing core side, consumes cfg_* and drives the outputs
// Signals:
//   cfg_enable    run (1) / idle (0), level, not double-buffered
//   cfg_polarity  1 inverts both PWM outputs
//   cfg_period    counter runs 0..period
//   cfg_duty      active-high count of pwm_h per period
//   cfg_prescale  one counter tick every prescale+1 clocks
//   cfg_deadtime  dead time in clock cycles
//   cfg_load      one-cycle strobe capturing all cfg_* except cfg_enable
//   pwm_h/pwm_l   complementary, dead-time protected outputs
//   period_pulse  one-cycle pulse per counter wrap
//   load_pending  captured configuration not yet applied
//   cnt_value     current main counter
interface pwm_gen_core_if #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16,
    parameter int DT_W  = 8
);
    logic             cfg_enable;
    logic             cfg_polarity;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;
    logic [PRE_W-1:0] cfg_prescale;
    logic [DT_W-1:0]  cfg_deadtime;
    logic             cfg_load;
    logic             pwm_h;
    logic             pwm_l;
    logic             period_pulse;
    logic             load_pending;
    logic [CNT_W-1:0] cnt_value;

    modport master (
        output cfg_enable, cfg_polarity, cfg_period, cfg_duty,
               cfg_prescale, cfg_deadtime, cfg_load,
        input  pwm_h, pwm_l, period_pulse, load_pending, cnt_value
    );

    modport slave (
        input  cfg_enable, cfg_polarity, cfg_period, cfg_duty,
               cfg_prescale, cfg_deadtime, cfg_load,
        output pwm_h, pwm_l, period_pulse, load_pending, cnt_value
    );
endinterface

// File: rtl/pwm_gen_core.sv
// pwm_gen_core
// Timing core of the PWM generator: prescaled main counter, double-buffered
// configuration, complementary outputs with single-counter dead time.
// Ports:
//   ACLK    clock, single domain
//   ARESET  asynchronous active-high reset
//   bus     pwm_gen_core_if slave modport (cfg_* in, PWM/status out)
module pwm_gen_core #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16,
    parameter int DT_W  = 8
) (
    input  logic           ACLK,
    input  logic           ARESET,
    pwm_gen_core_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] pre_cnt;

    logic [CNT_W-1:0] per_s, duty_s, per_p, duty_p;
    logic [PRE_W-1:0] pre_s, pre_p;
    logic [DT_W-1:0]  dt_s, dt_p;
    logic             pol_s, pol_p;
    logic             load_pending_q;

    logic             raw_h_q, raw_l_q;
    logic [DT_W-1:0]  dt_cnt;
    logic             pwm_h_q, pwm_l_q, pulse_q;

    logic             is_run, tick, wrap;
    logic             raw_h, raw_l, edge_seen, hold;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cfg_enable)  state_nxt = RUN;
            RUN:     if (!bus.cfg_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raw outputs are already forced off in the cycle enable drops, so the
    // registered outputs reach the idle level together with the counter reset.
    always_comb begin
        is_run    = (state == RUN);
        tick      = (pre_cnt == pre_s);
        wrap      = is_run && tick && (cnt == per_s);
        raw_h     = is_run && bus.cfg_enable && (cnt < duty_s);
        raw_l     = is_run && bus.cfg_enable && !(cnt < duty_s);
        edge_seen = (raw_h != raw_h_q) || (raw_l != raw_l_q);
        hold      = edge_seen ? (dt_s != '0) : (dt_cnt != '0);
    end

    // Wrap compare is checked before the increment so an all-ones period
    // never overflows.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt     <= '0;
            pre_cnt <= '0;
        end else if (!is_run || !bus.cfg_enable) begin
            cnt     <= '0;
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= wrap ? '0 : cnt + CNT_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // A load coinciding with a wrap bypasses the pending set entirely.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            per_s <= '0; duty_s <= '0; pre_s <= '0; dt_s <= '0; pol_s <= 1'b0;
            per_p <= '0; duty_p <= '0; pre_p <= '0; dt_p <= '0; pol_p <= 1'b0;
            load_pending_q <= 1'b0;
        end else if (bus.cfg_load) begin
            per_p  <= bus.cfg_period;
            duty_p <= bus.cfg_duty;
            pre_p  <= bus.cfg_prescale;
            dt_p   <= bus.cfg_deadtime;
            pol_p  <= bus.cfg_polarity;
            if (wrap) begin
                per_s  <= bus.cfg_period;
                duty_s <= bus.cfg_duty;
                pre_s  <= bus.cfg_prescale;
                dt_s   <= bus.cfg_deadtime;
                pol_s  <= bus.cfg_polarity;
                load_pending_q <= 1'b0;
            end else begin
                load_pending_q <= 1'b1;
            end
        end else if (load_pending_q && (!is_run || wrap)) begin
            per_s  <= per_p;
            duty_s <= duty_p;
            pre_s  <= pre_p;
            dt_s   <= dt_p;
            pol_s  <= pol_p;
            load_pending_q <= 1'b0;
        end
    end

    // One shared down-counter: any raw edge restarts it, and the cycle of the
    // edge itself already counts as the first held-off cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            raw_h_q <= 1'b0;
            raw_l_q <= 1'b0;
            dt_cnt  <= '0;
        end else begin
            raw_h_q <= raw_h;
            raw_l_q <= raw_l;
            if (edge_seen)
                dt_cnt <= (dt_s == '0) ? '0 : dt_s - DT_W'(1);
            else if (dt_cnt != '0)
                dt_cnt <= dt_cnt - DT_W'(1);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pwm_h_q <= (raw_h && !hold) ^ pol_s;
            pwm_l_q <= (raw_l && !hold) ^ pol_s;
            pulse_q <= wrap;
        end
    end

    assign bus.pwm_h        = pwm_h_q;
    assign bus.pwm_l        = pwm_l_q;
    assign bus.period_pulse = pulse_q;
    assign bus.load_pending = load_pending_q;
    assign bus.cnt_value    = cnt;

endmodule

// File: tb/tb_pwm_gen_core.sv
// tb_pwm_gen_core
// Directed plus randomized bench for pwm_gen_core. A behavioural model tracks
// the position inside the current period, the shadow/pending configuration and
// the time of the most recent raw edge, and predicts every output each cycle.
module tb_pwm_gen_core;

    logic ACLK;
    logic ARESET;

    pwm_gen_core_if #(.CNT_W(32), .PRE_W(16), .DT_W(8)) bus ();

    pwm_gen_core #(.CNT_W(32), .PRE_W(16), .DT_W(8)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_vectors    = 0;
    int n_miscompares = 0;

    // model state
    bit              m_run;
    longint unsigned m_k;
    logic [31:0]     s_per, s_duty, p_per, p_duty;
    logic [15:0]     s_pre, p_pre;
    logic [7:0]      s_dt, p_dt;
    logic            s_pol, p_pol;
    bit              m_lp;
    bit              prev_h, prev_l;
    longint          t_now, last_edge;
    int unsigned     hold_dt;
    // expected outputs for the current cycle
    logic            e_h, e_l, e_pp;
    logic [31:0]     e_cnt;

    task automatic check_sig(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_k = 0; m_lp = 0;
        s_per = 0; s_duty = 0; s_pre = 0; s_dt = 0; s_pol = 0;
        p_per = 0; p_duty = 0; p_pre = 0; p_dt = 0; p_pol = 0;
        prev_h = 0; prev_l = 0; hold_dt = 0; last_edge = t_now;
        e_h = 0; e_l = 0; e_pp = 0; e_cnt = 0;
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_update();
        logic [63:0] cnt_now, plen;
        bit raw_h, raw_l, open, wrap;
        t_now++;
        if (ARESET) begin
            model_reset();
            return;
        end
        cnt_now = m_k / ({48'd0, s_pre} + 64'd1);
        raw_h = m_run && bus.cfg_enable && (cnt_now < {32'd0, s_duty});
        raw_l = m_run && bus.cfg_enable && !(cnt_now < {32'd0, s_duty});
        if (raw_h != prev_h || raw_l != prev_l) begin
            last_edge = t_now;
            hold_dt   = s_dt;
        end
        open   = (t_now - last_edge) >= longint'(hold_dt);
        e_h    = (raw_h && open) ^ s_pol;
        e_l    = (raw_l && open) ^ s_pol;
        prev_h = raw_h;
        prev_l = raw_l;

        plen = ({32'd0, s_per} + 64'd1) * ({48'd0, s_pre} + 64'd1);
        wrap = m_run && (m_k == plen - 64'd1);
        e_pp = wrap;
        m_k  = (m_run && bus.cfg_enable && !wrap) ? m_k + 1 : 0;

        if (bus.cfg_load) begin
            p_per = bus.cfg_period; p_duty = bus.cfg_duty; p_pre = bus.cfg_prescale;
            p_dt = bus.cfg_deadtime; p_pol = bus.cfg_polarity;
            if (wrap) begin
                s_per = p_per; s_duty = p_duty; s_pre = p_pre; s_dt = p_dt; s_pol = p_pol;
                m_lp = 0;
            end else begin
                m_lp = 1;
            end
        end else if (m_lp && (!m_run || wrap)) begin
            s_per = p_per; s_duty = p_duty; s_pre = p_pre; s_dt = p_dt; s_pol = p_pol;
            m_lp = 0;
        end
        m_run = bus.cfg_enable;
        e_cnt = 32'(m_k / ({48'd0, s_pre} + 64'd1));
    endtask

    task automatic check_output();
        check_sig("pwm_h",        bus.pwm_h,        e_h);
        check_sig("pwm_l",        bus.pwm_l,        e_l);
        check_sig("period_pulse", bus.period_pulse, e_pp);
        check_sig("load_pending", bus.load_pending, m_lp);
        check_sig("cnt_value",    bus.cnt_value,    e_cnt);
    endtask

    task automatic apply_stimulus();
        model_update();
        @(posedge ACLK);
        #1;
        check_output();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic set_cfg(input logic [31:0] per, input logic [31:0] duty,
                           input logic [15:0] pre, input logic [7:0] dt, input logic pol);
        bus.cfg_period = per; bus.cfg_duty = duty; bus.cfg_prescale = pre;
        bus.cfg_deadtime = dt; bus.cfg_polarity = pol;
    endtask

    task automatic pulse_load();
        bus.cfg_load = 1'b1;
        apply_stimulus();
        bus.cfg_load = 1'b0;
    endtask

    task automatic wait_lp_clear();
        for (int i = 0; i < 300 && m_lp; i++) apply_stimulus();
        check_sig("wait_lp_clear", bus.load_pending, 0);
    endtask

    task automatic step_until_cnt(input logic [31:0] target);
        for (int i = 0; i < 300 && e_cnt != target; i++) apply_stimulus();
        check_sig("wait_cnt", bus.cnt_value, target);
    endtask

    // Counts DUT output activity over n cycles and compares with expectations.
    task automatic check_window(input string tag, input int n,
                                input int exp_h, input int exp_l, input int exp_pp);
        int ch = 0, cl = 0, cp = 0, cb = 0;
        for (int i = 0; i < n; i++) begin
            apply_stimulus();
            if (bus.pwm_h) ch++;
            if (bus.pwm_l) cl++;
            if (bus.period_pulse) cp++;
            if (bus.pwm_h && bus.pwm_l && !s_pol) cb++;
        end
        check_sig({tag, "_h_width"},  ch, exp_h);
        check_sig({tag, "_l_width"},  cl, exp_l);
        check_sig({tag, "_pulses"},   cp, exp_pp);
        check_sig({tag, "_overlap"},  cb, 0);
    endtask

    initial begin
        t_now = 0;
        model_reset();
        ARESET = 1'b1;
        bus.cfg_enable = 1'b0;
        bus.cfg_load   = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        run_cycles(3);
        ARESET = 1'b0;
        run_cycles(5);

        $display("[TB] basic PWM");
        set_cfg(9, 3, 0, 0, 0);
        pulse_load();
        run_cycles(2);
        bus.cfg_enable = 1'b1;
        run_cycles(12);
        check_window("basic", 10, 3, 7, 1);

        $display("[TB] prescale");
        set_cfg(4, 2, 1, 0, 0);
        pulse_load();
        wait_lp_clear();
        run_cycles(10);
        check_window("prescale", 10, 4, 6, 1);

        $display("[TB] dead time");
        set_cfg(9, 5, 0, 2, 0);
        pulse_load();
        wait_lp_clear();
        run_cycles(10);
        check_window("deadtime", 10, 3, 3, 1);

        $display("[TB] buffered update");
        set_cfg(9, 3, 0, 0, 0);
        pulse_load();
        wait_lp_clear();
        run_cycles(10);
        step_until_cnt(5);
        bus.cfg_duty = 7;
        pulse_load();
        check_sig("lp_after_load", bus.load_pending, 1);
        wait_lp_clear();
        check_window("dutyseven", 10, 7, 3, 1);
        step_until_cnt(9);
        bus.cfg_duty = 3;
        pulse_load();
        check_sig("lp_on_wrap_load", bus.load_pending, 0);
        check_window("wrapload", 10, 3, 7, 1);

        $display("[TB] boundaries");
        set_cfg(9, 0, 0, 0, 0);
        pulse_load();
        wait_lp_clear();
        run_cycles(10);
        check_window("duty0", 10, 0, 10, 1);
        set_cfg(9, 12, 0, 0, 0);
        pulse_load();
        wait_lp_clear();
        run_cycles(10);
        check_window("duty12", 10, 10, 0, 1);
        set_cfg(9, 3, 0, 0, 1);
        pulse_load();
        wait_lp_clear();
        run_cycles(10);
        check_window("polarity", 10, 7, 3, 1);
        step_until_cnt(4);
        bus.cfg_enable = 1'b0;
        apply_stimulus();
        check_sig("drop_en_h",   bus.pwm_h, 1);
        check_sig("drop_en_l",   bus.pwm_l, 1);
        check_sig("drop_en_cnt", bus.cnt_value, 0);
        run_cycles(4);

        $display("[TB] random");
        for (int i = 0; i < 800; i++) begin
            bus.cfg_enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) begin
                set_cfg($urandom_range(0, 12), $urandom_range(0, 14),
                        16'($urandom_range(0, 3)), 8'($urandom_range(0, 4)),
                        1'($urandom_range(0, 1)));
                bus.cfg_load = 1'b1;
            end else begin
                bus.cfg_load = 1'b0;
            end
            apply_stimulus();
        end
        bus.cfg_load = 1'b0;

        $display("[TB] async reset mid-run");
        bus.cfg_enable = 1'b1;
        set_cfg(9, 3, 0, 1, 0);
        pulse_load();
        run_cycles(25);
        step_until_cnt(2);
        #2;
        ARESET = 1'b1;
        #1;
        check_sig("arst_pwm_h", bus.pwm_h, 0);
        check_sig("arst_pwm_l", bus.pwm_l, 0);
        check_sig("arst_pulse", bus.period_pulse, 0);
        check_sig("arst_lp",    bus.load_pending, 0);
        check_sig("arst_cnt",   bus.cnt_value, 0);
        bus.cfg_enable = 1'b0;
        run_cycles(2);
        ARESET = 1'b0;
        run_cycles(5);
        check_sig("idle_after_rst_cnt", bus.cnt_value, 0);
        bus.cfg_enable = 1'b1;
        run_cycles(20);

        $display("[TB] all-ones period");
        bus.cfg_enable = 1'b0;
        run_cycles(2);
        set_cfg(32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0);
        pulse_load();
        run_cycles(3);
        bus.cfg_enable = 1'b1;
        run_cycles(40);
        check_sig("allones_cnt", bus.cnt_value, 39);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
